// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Request/response and memory-bus bundle for dmem_arbiter.
//               The slave side is the arbiter. The master side is the
//               requesters plus the data memory, which returns mem_rdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
  // Requester port 0 (pipeline MEM stage) and port 1 (test/loader)
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [63:0] addr0;
  logic [63:0] addr1;
  logic [63:0] wdata0;
  logic [63:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [63:0] rdata0;
  logic [63:0] rdata1;
  logic        err0;
  logic        err1;
  // Single-ported data memory
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;
  // Status
  logic        busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_write, mem_read, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_write, mem_read, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter and access sequencer for a single-ported
//               32-bit-word data memory. One access per two cycles:
//               arbitrate -> ACCESS (gnt, memory strobe) -> RESP (done/err).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES  = 512,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  // Highest legal word address; compared against the full 64-bit address
  localparam logic [63:0] c_last_addr = 64'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        rejected_q, rejected_d;
  logic        last_owner_q, last_owner_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic [63:0] rdata0_q, rdata0_d;
  logic [63:0] rdata1_q, rdata1_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        any_req;
  logic        win_port;
  logic        win_we;
  logic        win_rejected;
  logic [63:0] win_addr;
  logic [63:0] win_wdata;

  // Pick the winner from the live requests and qualify its address.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      win_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner_q;
    end else begin
      win_port = bus.req1;
    end
    win_we       = win_port ? bus.we1    : bus.we0;
    win_addr     = win_port ? bus.addr1  : bus.addr0;
    win_wdata    = win_port ? bus.wdata1 : bus.wdata0;
    win_rejected = (win_addr[1:0] != 2'b00) || (win_addr > c_last_addr);
  end

  // Next-state and next-output logic; all strobes are precomputed one
  // cycle ahead so the outputs come straight from flops.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    rejected_d   = rejected_q;
    last_owner_d = last_owner_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;

    case (state_q)
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (owner_q) begin
          done1_d = 1'b1;
          err1_d  = rejected_q;
        end else begin
          done0_d = 1'b1;
          err0_d  = rejected_q;
        end
        // Rejected reads return zero; writes leave the read result alone
        if (!we_q) begin
          if (owner_q) begin
            rdata1_d = rejected_q ? 64'h0 : bus.mem_rdata;
          end else begin
            rdata0_d = rejected_q ? 64'h0 : bus.mem_rdata;
          end
        end
      end
      default: begin
        // IDLE and RESP both arbitrate, giving back-to-back throughput
        if (any_req) begin
          state_d      = ST_ACCESS;
          owner_d      = win_port;
          we_d         = win_we;
          rejected_d   = win_rejected;
          last_owner_d = win_port;
          mem_addr_d   = win_addr;
          mem_wdata_d  = win_wdata;
          gnt0_d       = ~win_port;
          gnt1_d       = win_port;
          mem_read_d   = ~win_we & ~win_rejected;
          mem_write_d  = win_we & ~win_rejected;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      rejected_q   <= 1'b0;
      last_owner_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= 64'h0;
      rdata1_q     <= 64'h0;
      mem_addr_q   <= 64'h0;
      mem_wdata_q  <= 64'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      rejected_q   <= rejected_d;
      last_owner_q <= last_owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  // A reset arriving during ACCESS must kill the write in the same cycle
  assign bus.mem_write = mem_write_q & ~reset;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a byte-array data
//               memory and a word-level reference model of its contents.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();
  dmem_arbiter_if bus_fp();

  dmem_arbiter #(.MEM_BYTES(512), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  dmem_arbiter #(.MEM_BYTES(512), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset), .bus(bus_fp)
  );

  int errors = 0;
  int checks = 0;

  // Data memory: 512 bytes, little-endian, combinational read
  logic [7:0]  mem [0:511];
  logic        poke_en;
  int          poke_addr;
  logic [31:0] poke_data;
  logic [8:0]  rd_idx;

  always_comb begin
    rd_idx = bus.mem_addr[8:0];
    if (bus.mem_addr <= 64'd508)
      bus.mem_rdata = {32'h0, mem[rd_idx + 9'd3], mem[rd_idx + 9'd2],
                       mem[rd_idx + 9'd1], mem[rd_idx]};
    else
      bus.mem_rdata = 64'h0;
  end

  always @(posedge clk) begin
    if (poke_en) begin
      for (int i = 0; i < 4; i++) mem[poke_addr + i] <= poke_data[8*i +: 8];
    end else if (bus.mem_write && (bus.mem_addr <= 64'd508)) begin
      for (int i = 0; i < 4; i++)
        mem[int'(bus.mem_addr[8:0]) + i] <= bus.mem_wdata[8*i +: 8];
    end
  end

  assign bus_fp.mem_rdata = 64'h0;

  // Reference model state
  logic [31:0] ref_word [0:127];
  logic [63:0] exp_rd [0:1];
  int          last_winner;

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  function automatic bit rule_rejected(input logic [63:0] a);
    return (a % 64'd4 != 64'd0) || (a > 64'd508);
  endfunction

  // Drive one access on port p and collect what the DUT showed.
  task automatic run_access(input int p, input bit we, input logic [63:0] addr,
                            input logic [63:0] wdata, output bit tmo,
                            output int lat, output bit g_mrd, output bit g_mwr,
                            output logic [63:0] g_maddr, output bit d_done,
                            output bit d_err, output logic [63:0] d_rdata);
    @(negedge clk);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
    tmo = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((p == 0 && bus.gnt0) || (p == 1 && bus.gnt1)) begin
        lat = k;
        tmo = 1'b0;
        break;
      end
    end
    g_mrd   = bus.mem_read;
    g_mwr   = bus.mem_write;
    g_maddr = bus.mem_addr;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    d_done  = (p == 0) ? bus.done0  : bus.done1;
    d_err   = (p == 0) ? bus.err0   : bus.err1;
    d_rdata = (p == 0) ? bus.rdata0 : bus.rdata1;
    if (!tmo) last_winner = p;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1});
    end
    checks++;
    if (bus.rdata0 !== 64'h0 || bus.rdata1 !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h want 0 0", bus.rdata0, bus.rdata1);
    end
    checks++;
    if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0 ||
        bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h rd=%b wr=%b busy=%b want all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_read, bus.mem_write, bus.busy);
    end
    last_winner = 1;
    exp_rd[0] = 64'h0;
    exp_rd[1] = 64'h0;
  endtask

  task automatic test_single_read();
    bit tmo, mrd, mwr, dn, er; int lat; logic [63:0] ma, rd;
    run_access(0, 1'b0, 64'd256, 64'h0, tmo, lat, mrd, mwr, ma, dn, er, rd);
    checks++;
    if (tmo || lat != 1) begin
      errors++; $display("FAIL single_gnt_latency: got %0d (timeout=%b) want 1", lat, tmo);
    end
    checks++;
    if (mrd !== 1'b1 || mwr !== 1'b0 || ma !== 64'd256) begin
      errors++; $display("FAIL single_mem_bus: rd=%b wr=%b addr=%0d want 1 0 256", mrd, mwr, ma);
    end
    checks++;
    if (dn !== 1'b1 || er !== 1'b0 || rd !== 64'h7) begin
      errors++; $display("FAIL single_resp: done=%b err=%b rdata=%h want 1 0 7", dn, er, rd);
    end
    exp_rd[0] = 64'h7;
  endtask

  task automatic test_write_read();
    bit tmo, mrd, mwr, dn, er; int lat; logic [63:0] ma, rd;
    run_access(1, 1'b1, 64'd260, 64'hFFFF_FFFF_DEAD_BEEF, tmo, lat, mrd, mwr, ma, dn, er, rd);
    checks++;
    if (tmo || mwr !== 1'b1 || mrd !== 1'b0) begin
      errors++; $display("FAIL wr_strobe: wr=%b rd=%b timeout=%b want 1 0 0", mwr, mrd, tmo);
    end
    checks++;
    if (mem[260] !== 8'hEF || mem[261] !== 8'hBE || mem[262] !== 8'hAD || mem[263] !== 8'hDE) begin
      errors++; $display("FAIL wr_bytes: got %h %h %h %h want ef be ad de",
                         mem[260], mem[261], mem[262], mem[263]);
    end
    checks++;
    if (dn !== 1'b1 || er !== 1'b0 || rd !== exp_rd[1]) begin
      errors++; $display("FAIL wr_resp: done=%b err=%b rdata=%h want 1 0 %h", dn, er, rd, exp_rd[1]);
    end
    ref_word[65] = 32'hDEAD_BEEF;
    run_access(1, 1'b0, 64'd260, 64'h0, tmo, lat, mrd, mwr, ma, dn, er, rd);
    checks++;
    if (tmo || dn !== 1'b1 || er !== 1'b0 || rd !== 64'h0000_0000_DEAD_BEEF) begin
      errors++; $display("FAIL rd_after_wr: done=%b err=%b rdata=%h want 1 0 00000000deadbeef", dn, er, rd);
    end
    exp_rd[1] = 64'h0000_0000_DEAD_BEEF;
  endtask

  task automatic test_error_path();
    bit tmo, mrd, mwr, dn, er; int lat; logic [63:0] ma, rd;
    logic [63:0] bad [0:2];
    bad[0] = 64'd258; bad[1] = 64'd512; bad[2] = 64'h8000_0000_0000_0100;
    for (int i = 0; i < 3; i++) begin
      run_access(0, 1'b0, 64'd256, 64'h0, tmo, lat, mrd, mwr, ma, dn, er, rd);
      checks++;
      if (tmo || rd !== 64'h7 || er !== 1'b0) begin
        errors++; $display("FAIL err_prime_%0d: rdata=%h err=%b want 7 0", i, rd, er);
      end
      run_access(0, 1'b0, bad[i], 64'h0, tmo, lat, mrd, mwr, ma, dn, er, rd);
      checks++;
      if (tmo || mrd !== 1'b0 || mwr !== 1'b0) begin
        errors++; $display("FAIL err_strobe_%0d: rd=%b wr=%b want 0 0", i, mrd, mwr);
      end
      checks++;
      if (dn !== 1'b1 || er !== 1'b1 || rd !== 64'h0) begin
        errors++; $display("FAIL err_resp_%0d: done=%b err=%b rdata=%h want 1 1 0", i, dn, er, rd);
      end
    end
    exp_rd[0] = 64'h0;
    run_access(1, 1'b1, 64'd510, 64'h1234_5678, tmo, lat, mrd, mwr, ma, dn, er, rd);
    checks++;
    if (tmo || mwr !== 1'b0 || dn !== 1'b1 || er !== 1'b1) begin
      errors++; $display("FAIL err_wr510: wr=%b done=%b err=%b want 0 1 1", mwr, dn, er);
    end
    checks++;
    if (mem_word(508) !== ref_word[127]) begin
      errors++; $display("FAIL err_wr510_mem: got %h want %h", mem_word(508), ref_word[127]);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 64'd256;
    k = 0;
    while (!bus.gnt0 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++; $display("FAIL b2b_gnt_a: gnt0=%b want 1", bus.gnt0);
    end
    bus.addr0 = 64'd268;
    @(negedge clk);
    checks++;
    if (bus.done0 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.rdata0 !== {32'h0, ref_word[64]}) begin
      errors++; $display("FAIL b2b_done_a: done0=%b gnt0=%b rdata0=%h want 1 0 %h",
                         bus.done0, bus.gnt0, bus.rdata0, {32'h0, ref_word[64]});
    end
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.done0 !== 1'b0 || bus.mem_addr !== 64'd268) begin
      errors++; $display("FAIL b2b_gnt_b: gnt0=%b done0=%b addr=%0d want 1 0 268",
                         bus.gnt0, bus.done0, bus.mem_addr);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done0 !== 1'b1 || bus.rdata0 !== 64'h4) begin
      errors++; $display("FAIL b2b_done_b: done0=%b rdata0=%h want 1 4", bus.done0, bus.rdata0);
    end
    exp_rd[0] = 64'h4;
    last_winner = 0;
  endtask

  task automatic test_round_robin();
    int exp_port;
    bit eg0, eg1;
    exp_port = (last_winner == 1) ? 0 : 1;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 64'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 64'd4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      eg0 = (k % 2 == 1) && (exp_port == 0);
      eg1 = (k % 2 == 1) && (exp_port == 1);
      checks++;
      if (bus.gnt0 !== eg0 || bus.gnt1 !== eg1) begin
        errors++; $display("FAIL rr_gnt_cycle%0d: gnt0=%b gnt1=%b want %b %b",
                           k, bus.gnt0, bus.gnt1, eg0, eg1);
      end
      if (k % 2 == 0) begin
        checks++;
        if ((exp_port == 0 && (bus.done0 !== 1'b1 || bus.rdata0 !== {32'h0, ref_word[0]})) ||
            (exp_port == 1 && (bus.done1 !== 1'b1 || bus.rdata1 !== {32'h0, ref_word[1]}))) begin
          errors++; $display("FAIL rr_done_cycle%0d: port=%0d done=%b%b rdata0=%h rdata1=%h",
                             k, exp_port, bus.done0, bus.done1, bus.rdata0, bus.rdata1);
        end
        exp_rd[exp_port] = {32'h0, ref_word[exp_port]};
        last_winner = exp_port;
        exp_port = 1 - exp_port;
      end
      if (k == 8) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
  endtask

  task automatic test_fixed_prio();
    @(negedge clk);
    bus_fp.req0 = 1'b1; bus_fp.we0 = 1'b0; bus_fp.addr0 = 64'd0;
    bus_fp.req1 = 1'b1; bus_fp.we1 = 1'b0; bus_fp.addr1 = 64'd4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus_fp.gnt0 !== (k % 2 == 1) || bus_fp.gnt1 !== 1'b0) begin
        errors++; $display("FAIL fp_gnt_cycle%0d: gnt0=%b gnt1=%b want %b 0",
                           k, bus_fp.gnt0, bus_fp.gnt1, (k % 2 == 1));
      end
      if (k == 8) begin
        bus_fp.req0 = 1'b0;
        bus_fp.req1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_access();
    int k;
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 64'd264; bus.wdata1 = 64'h55;
    k = 0;
    while (!bus.gnt1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.mem_write !== 1'b1) begin
      errors++; $display("FAIL rst_acc_gnt: gnt1=%b mem_write=%b want 1 1", bus.gnt1, bus.mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL rst_acc_wr_abort: mem_write=%b want 0", bus.mem_write);
    end
    bus.req1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done1 !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rst_acc_idle%0d: done1=%b busy=%b want 0 0", i, bus.done1, bus.busy);
      end
      if (i == 1) reset = 1'b0;
    end
    checks++;
    if (mem_word(264) !== 32'h5) begin
      errors++; $display("FAIL rst_acc_mem: got %h want 00000005", mem_word(264));
    end
    last_winner = 1;
    exp_rd[0] = 64'h0;
    exp_rd[1] = 64'h0;
  endtask

  task automatic test_random();
    bit tmo, mrd, mwr, dn, er, we, e_err; int lat, p, kind, lo; logic [63:0] ma, rd, addr, wd;
    for (int n = 0; n < 60; n++) begin
      p    = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 6);
      lo   = $urandom_range(0, 127);
      case (kind)
        0, 1, 2: addr = 64'(lo) * 64'd4;
        3:       addr = 64'(lo) * 64'd4 + 64'($urandom_range(1, 3));
        4:       addr = 64'd512 + 64'($urandom_range(0, 255));
        5:       addr = (kind[0]) ? 64'd508 : 64'd512;
        default: addr = {($urandom | 32'h1), 32'(lo * 4)};
      endcase
      wd = {$urandom, $urandom};
      e_err = rule_rejected(addr);
      run_access(p, we, addr, wd, tmo, lat, mrd, mwr, ma, dn, er, rd);
      checks++;
      if (tmo || lat != 1 || ma !== addr || mrd !== (!we && !e_err) || mwr !== (we && !e_err)) begin
        errors++; $display("FAIL rnd%0d_access: p=%0d we=%b addr=%h lat=%0d maddr=%h rd=%b wr=%b err_exp=%b",
                           n, p, we, addr, lat, ma, mrd, mwr, e_err);
      end
      if (!we) exp_rd[p] = e_err ? 64'h0 : {32'h0, ref_word[addr[8:2]]};
      checks++;
      if (dn !== 1'b1 || er !== e_err || rd !== exp_rd[p]) begin
        errors++; $display("FAIL rnd%0d_resp: p=%0d we=%b addr=%h done=%b err=%b rdata=%h want 1 %b %h",
                           n, p, we, addr, dn, er, rd, e_err, exp_rd[p]);
      end
      if (we && !e_err) begin
        ref_word[addr[8:2]] = wd[31:0];
        checks++;
        if (mem_word(int'(addr[8:0])) !== wd[31:0]) begin
          errors++; $display("FAIL rnd%0d_mem: addr=%h got %h want %h",
                             n, addr, mem_word(int'(addr[8:0])), wd[31:0]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    poke_en = 1'b0; poke_addr = 0; poke_data = 32'h0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 64'h0; bus.addr1 = 64'h0; bus.wdata0 = 64'h0; bus.wdata1 = 64'h0;
    bus_fp.req0 = 1'b0; bus_fp.req1 = 1'b0; bus_fp.we0 = 1'b0; bus_fp.we1 = 1'b0;
    bus_fp.addr0 = 64'h0; bus_fp.addr1 = 64'h0; bus_fp.wdata0 = 64'h0; bus_fp.wdata1 = 64'h0;
    // Preload memory with random words plus the fixed test values
    for (int w = 0; w < 128; w++) begin
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = w * 4;
      case (w)
        64:      poke_data = 32'h7;
        65:      poke_data = 32'h0;
        66:      poke_data = 32'h5;
        67:      poke_data = 32'h4;
        default: poke_data = $urandom;
      endcase
      ref_word[w] = poke_data;
    end
    @(negedge clk);
    poke_en = 1'b0;

    test_reset();
    reset = 1'b0;
    test_single_read();
    test_write_read();
    test_error_path();
    test_back_to_back();
    test_round_robin();
    test_fixed_prio();
    test_reset_in_access();
    test_round_robin();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
